// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the stack CPU microsequencer: strobe bit positions,
// ALU codes, opcodes and the controller state encoding.
package cpu_ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned LD_W    = 9;
  localparam int unsigned TR_W    = 6;
  localparam int unsigned ALOP_W  = 3;
  localparam int unsigned WAIT_W  = 16;

  localparam int unsigned LD_R   = 0;
  localparam int unsigned LD_PC  = 1;
  localparam int unsigned LD_SP  = 2;
  localparam int unsigned LD_F   = 3;
  localparam int unsigned LD_T   = 4;
  localparam int unsigned LD_MAR = 5;
  localparam int unsigned LD_MDM = 6;
  localparam int unsigned LD_MDZ = 7;
  localparam int unsigned LD_IR  = 8;

  localparam int unsigned TR_R   = 0;
  localparam int unsigned TR_PC  = 1;
  localparam int unsigned TR_SP  = 2;
  localparam int unsigned TR_MAR = 3;
  localparam int unsigned TR_MDR = 4;
  localparam int unsigned TR_L   = 5;

  localparam logic [ALOP_W-1:0] ALOP_ADD   = 3'b000;
  localparam logic [ALOP_W-1:0] ALOP_SUB   = 3'b001;
  localparam logic [ALOP_W-1:0] ALOP_AND   = 3'b010;
  localparam logic [ALOP_W-1:0] ALOP_OR    = 3'b011;
  localparam logic [ALOP_W-1:0] ALOP_XOR   = 3'b100;
  localparam logic [ALOP_W-1:0] ALOP_PASSX = 3'b101;
  localparam logic [ALOP_W-1:0] ALOP_INCX  = 3'b110;
  localparam logic [ALOP_W-1:0] ALOP_DECX  = 3'b111;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_PUSH = 4'h1;
  localparam logic [3:0] OP_POP  = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_CALL = 4'h4;
  localparam logic [3:0] OP_RET  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'h6;

  typedef enum logic [4:0] {
    S_RST, S_F0, S_F1, S_F2, S_DEC,
    S_AL1, S_AL2, S_AL3, S_AL4, S_AL5, S_AL6, S_AL7,
    S_PU1, S_PU2, S_PU3,
    S_PO1, S_PO2, S_PO3, S_PO4,
    S_RT1, S_RT2, S_RT3, S_RT4,
    S_CA1, S_CA2, S_CA3,
    S_J1, S_J2, S_HLT, S_ERR
  } state_e;

  function automatic logic is_read_wait(input state_e s);
    return s inside {S_F1, S_AL2, S_AL5, S_PO2, S_RT2};
  endfunction

  function automatic logic is_write_wait(input state_e s);
    return s inside {S_AL7, S_PU3, S_CA3};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a wait state and flags a timeout
// once MAX_WAIT cycles have passed without completion (MAX_WAIT=0 disables).
module mem_wait_timer import cpu_ctrl_pkg::*; #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_wait,
  input  logic i_ready,
  output logic o_timeout_c
);

  logic [WAIT_W-1:0] r_count;

  // Holds the number of earlier cycles spent in the current wait; clears on exit.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wait || i_ready) begin
      r_count <= '0;
    end else if (r_count != '1) begin
      r_count <= r_count + WAIT_W'(1);
    end
  end

  assign o_timeout_c = (MAX_WAIT != 0) && i_wait && !i_ready &&
                       ((32'(r_count) + 32'd1) >= MAX_WAIT);

endmodule

// File: rtl/stack_control_unit.sv
// Multi-cycle microsequencer for the 16-bit stack CPU: fetch, decode and
// per-opcode micro-steps, with memory wait states and timeout to an error halt.
module stack_control_unit import cpu_ctrl_pkg::*; #(
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Status,
  input  logic               mem_ready,
  output logic [LD_W-1:0]    LoadSignal,
  output logic [TR_W-1:0]    TransferSignal,
  output logic [ALOP_W-1:0]  ALOP,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               fetch,
  output logic               halted,
  output logic               err
);

  state_e r_state, w_next;
  logic   w_wait, w_timeout, w_unused;

  // Operand/register fields of IR are consumed by the datapath, not here.
  assign w_unused = ^Instruction[11:3];
  assign w_wait   = is_read_wait(r_state) || is_write_wait(r_state);

  mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_wait      (w_wait),
    .i_ready     (mem_ready),
    .o_timeout_c (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    LoadSignal     = '0;
    TransferSignal = '0;
    ALOP           = ALOP_ADD;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    fetch          = 1'b0;
    halted         = 1'b0;
    err            = 1'b0;
    case (r_state)
      S_RST: w_next = S_F0;
      S_F0: begin
        fetch = 1'b1; TransferSignal[TR_PC] = 1'b1; ALOP = ALOP_PASSX;
        LoadSignal[LD_MAR] = 1'b1; w_next = S_F1;
      end
      S_F1: begin mem_rd = 1'b1; LoadSignal[LD_IR] = mem_ready; w_next = S_F2; end
      S_F2: begin
        TransferSignal[TR_PC] = 1'b1; ALOP = ALOP_INCX; LoadSignal[LD_PC] = 1'b1;
        w_next = S_DEC;
      end
      S_DEC: begin
        if (Instruction[15]) begin
          w_next = Status ? S_J1 : S_F0;
        end else begin
          case (Instruction[15:12])
            OP_ALU:  w_next = S_AL1;
            OP_PUSH: w_next = S_PU1;
            OP_POP:  w_next = S_PO1;
            OP_JMP:  w_next = S_J1;
            OP_CALL: w_next = S_CA1;
            OP_RET:  w_next = S_RT1;
            OP_HALT: w_next = S_HLT;
            default: w_next = S_F0;
          endcase
        end
      end
      // Add/sub/logic on the two top-of-stack words; result replaces the second.
      S_AL1: begin TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_MAR] = 1'b1; w_next = S_AL2; end
      S_AL2: begin mem_rd = 1'b1; LoadSignal[LD_MDM] = mem_ready; w_next = S_AL3; end
      S_AL3: begin TransferSignal[TR_MDR] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_T] = 1'b1; w_next = S_AL4; end
      S_AL4: begin
        TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_INCX;
        LoadSignal[LD_SP] = 1'b1; LoadSignal[LD_MAR] = 1'b1; w_next = S_AL5;
      end
      S_AL5: begin mem_rd = 1'b1; LoadSignal[LD_MDM] = mem_ready; w_next = S_AL6; end
      S_AL6: begin
        TransferSignal[TR_MDR] = 1'b1; ALOP = Instruction[2:0];
        LoadSignal[LD_MDZ] = 1'b1; LoadSignal[LD_F] = 1'b1; w_next = S_AL7;
      end
      S_AL7: begin mem_wr = 1'b1; w_next = S_F0; end
      S_PU1: begin TransferSignal[TR_R] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_MDZ] = 1'b1; w_next = S_PU2; end
      S_PU2: begin
        TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_DECX;
        LoadSignal[LD_SP] = 1'b1; LoadSignal[LD_MAR] = 1'b1; w_next = S_PU3;
      end
      S_PU3: begin mem_wr = 1'b1; w_next = S_F0; end
      S_PO1: begin TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_MAR] = 1'b1; w_next = S_PO2; end
      S_PO2: begin mem_rd = 1'b1; LoadSignal[LD_MDM] = mem_ready; w_next = S_PO3; end
      S_PO3: begin TransferSignal[TR_MDR] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_R] = 1'b1; w_next = S_PO4; end
      S_PO4: begin TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_INCX; LoadSignal[LD_SP] = 1'b1; w_next = S_F0; end
      S_RT1: begin TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_MAR] = 1'b1; w_next = S_RT2; end
      S_RT2: begin mem_rd = 1'b1; LoadSignal[LD_MDM] = mem_ready; w_next = S_RT3; end
      S_RT3: begin TransferSignal[TR_MDR] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_PC] = 1'b1; w_next = S_RT4; end
      S_RT4: begin TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_INCX; LoadSignal[LD_SP] = 1'b1; w_next = S_F0; end
      // CALL pushes the return address, then shares the JMP steps.
      S_CA1: begin TransferSignal[TR_PC] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_MDZ] = 1'b1; w_next = S_CA2; end
      S_CA2: begin
        TransferSignal[TR_SP] = 1'b1; ALOP = ALOP_DECX;
        LoadSignal[LD_SP] = 1'b1; LoadSignal[LD_MAR] = 1'b1; w_next = S_CA3;
      end
      S_CA3: begin mem_wr = 1'b1; w_next = S_J1; end
      S_J1:  begin TransferSignal[TR_L] = 1'b1; ALOP = ALOP_PASSX; LoadSignal[LD_T] = 1'b1; w_next = S_J2; end
      S_J2:  begin TransferSignal[TR_PC] = 1'b1; ALOP = ALOP_ADD; LoadSignal[LD_PC] = 1'b1; w_next = S_F0; end
      S_HLT: halted = 1'b1;
      S_ERR: begin halted = 1'b1; err = 1'b1; end
      default: w_next = S_RST;
    endcase
    // Wait states hold until memory completes, or give up on timeout.
    if (w_wait && !mem_ready) w_next = r_state;
    if (w_timeout)            w_next = S_ERR;
  end

endmodule

// File: tb/tb_stack_control_unit.sv
// Randomized bench for stack_control_unit: each instruction is expanded into
// its expected micro-step list and compared cycle by cycle against the DUT.
module tb_stack_control_unit;

  localparam int unsigned MAXW = 8;

  localparam logic [8:0] LR = 9'h001, LPC = 9'h002, LSP = 9'h004, LF = 9'h008, LT = 9'h010;
  localparam logic [8:0] LMAR = 9'h020, LMDM = 9'h040, LMDZ = 9'h080, LIR = 9'h100;
  localparam logic [5:0] TRR = 6'h01, TPC = 6'h02, TSP = 6'h04, TMDR = 6'h10, TL = 6'h20;
  localparam logic [2:0] A_ADD = 3'd0, A_PASS = 3'd5, A_INC = 3'd6, A_DEC = 3'd7;
  localparam logic [1:0] K_NONE = 2'd0, K_RD = 2'd1, K_WR = 2'd2;

  typedef struct packed {
    logic [8:0] ld;
    logic [5:0] tr;
    logic [2:0] alop;
    logic [1:0] kind;
    logic       fe;
  } step_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] Instruction;
  logic        Status, mem_ready;
  logic [8:0]  LoadSignal;
  logic [5:0]  TransferSignal;
  logic [2:0]  ALOP;
  logic        mem_rd, mem_wr, fetch, halted, err;

  int    n_checks = 0;
  int    n_errors = 0;
  step_t q[$];

  always #5 clk = ~clk;

  stack_control_unit #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .Instruction(Instruction), .Status(Status),
    .mem_ready(mem_ready), .LoadSignal(LoadSignal), .TransferSignal(TransferSignal),
    .ALOP(ALOP), .mem_rd(mem_rd), .mem_wr(mem_wr), .fetch(fetch),
    .halted(halted), .err(err)
  );

  wire [22:0] obs = {LoadSignal, TransferSignal, ALOP, mem_rd, mem_wr, fetch, halted, err};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] ev(input logic [8:0] ld, input logic [5:0] tr,
                                     input logic [2:0] al, input logic rd, input logic wr,
                                     input logic fe, input logic ha, input logic er);
    return {ld, tr, al, rd, wr, fe, ha, er};
  endfunction

  function automatic step_t mk(input logic [8:0] ld, input logic [5:0] tr,
                               input logic [2:0] al, input logic [1:0] kind, input logic fe);
    step_t s;
    s.ld = ld; s.tr = tr; s.alop = al; s.kind = kind; s.fe = fe;
    return s;
  endfunction

  // One clock: compare outputs mid-cycle, then advance past the next edge.
  task automatic cycle(input string tag, input logic [22:0] exp);
    @(negedge clk);
    check_eq(tag, 32'(obs), 32'(exp));
    check_eq("inv_tr_onehot", 32'($onehot0(TransferSignal)), 32'd1);
    check_eq("inv_mdm_mdz", 32'(LoadSignal[6] & LoadSignal[7]), 32'd0);
    check_eq("inv_rd_wr", 32'(mem_rd & mem_wr), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic push_jmp();
    q.push_back(mk(LT, TL, A_PASS, K_NONE, 1'b0));
    q.push_back(mk(LPC, TPC, A_ADD, K_NONE, 1'b0));
  endtask

  // Expected micro-steps for one instruction, straight from the opcode table.
  task automatic build(input logic [15:0] ir, input logic st);
    q.delete();
    q.push_back(mk(LMAR, TPC, A_PASS, K_NONE, 1'b1));
    q.push_back(mk(LIR, 6'h0, 3'd0, K_RD, 1'b0));
    q.push_back(mk(LPC, TPC, A_INC, K_NONE, 1'b0));
    q.push_back(mk(9'h0, 6'h0, 3'd0, K_NONE, 1'b0));
    if (ir[15]) begin
      if (st) push_jmp();
    end else begin
      case (ir[14:12])
        3'd0: begin
          q.push_back(mk(LMAR, TSP, A_PASS, K_NONE, 1'b0));
          q.push_back(mk(LMDM, 6'h0, 3'd0, K_RD, 1'b0));
          q.push_back(mk(LT, TMDR, A_PASS, K_NONE, 1'b0));
          q.push_back(mk(LSP | LMAR, TSP, A_INC, K_NONE, 1'b0));
          q.push_back(mk(LMDM, 6'h0, 3'd0, K_RD, 1'b0));
          q.push_back(mk(LMDZ | LF, TMDR, ir[2:0], K_NONE, 1'b0));
          q.push_back(mk(9'h0, 6'h0, 3'd0, K_WR, 1'b0));
        end
        3'd1: begin
          q.push_back(mk(LMDZ, TRR, A_PASS, K_NONE, 1'b0));
          q.push_back(mk(LSP | LMAR, TSP, A_DEC, K_NONE, 1'b0));
          q.push_back(mk(9'h0, 6'h0, 3'd0, K_WR, 1'b0));
        end
        3'd2, 3'd5: begin
          q.push_back(mk(LMAR, TSP, A_PASS, K_NONE, 1'b0));
          q.push_back(mk(LMDM, 6'h0, 3'd0, K_RD, 1'b0));
          q.push_back(mk((ir[14:12] == 3'd2) ? LR : LPC, TMDR, A_PASS, K_NONE, 1'b0));
          q.push_back(mk(LSP, TSP, A_INC, K_NONE, 1'b0));
        end
        3'd3: push_jmp();
        3'd4: begin
          q.push_back(mk(LMDZ, TPC, A_PASS, K_NONE, 1'b0));
          q.push_back(mk(LSP | LMAR, TSP, A_DEC, K_NONE, 1'b0));
          q.push_back(mk(9'h0, 6'h0, 3'd0, K_WR, 1'b0));
          push_jmp();
        end
        default: ;
      endcase
    end
  endtask

  // Runs one instruction; code 0 = back to fetch, 1 = halted, 2 = timed out.
  task automatic exec(input logic [15:0] ir, input logic st, input int unsigned dmin,
                      input int unsigned dmax, input int abort_at, output int code);
    code = 0;
    Instruction = ir;
    build(ir, st);
    foreach (q[i]) begin
      step_t s;
      string tag;
      s = q[i];
      tag = $sformatf("ir%h_step%0d", ir, i);
      if (s.kind == K_NONE) begin
        mem_ready = 1'($urandom);
        Status = (i == 3) ? st : 1'($urandom);
        cycle(tag, ev(s.ld, s.tr, s.alop, 1'b0, 1'b0, s.fe, 1'b0, 1'b0));
      end else begin
        int unsigned d;
        d = $urandom_range(dmax, dmin);
        for (int unsigned k = 0; k < d && k < MAXW; k++) begin
          mem_ready = 1'b0;
          Status = 1'($urandom);
          cycle({tag, "_wait"}, ev(9'h0, 6'h0, 3'd0, s.kind == K_RD, s.kind == K_WR, 1'b0, 1'b0, 1'b0));
          if (i == abort_at) return;
        end
        if (d >= MAXW) begin
          code = 2;
          return;
        end
        mem_ready = 1'b1;
        cycle({tag, "_done"}, ev((s.kind == K_RD) ? s.ld : 9'h0, 6'h0, 3'd0,
                                 s.kind == K_RD, s.kind == K_WR, 1'b0, 1'b0, 1'b0));
      end
    end
    if (ir[15:12] == 4'h6) code = 1;
  endtask

  task automatic hold_check(input int n, input logic er);
    for (int i = 0; i < n; i++) begin
      mem_ready = 1'($urandom);
      Status = 1'($urandom);
      Instruction = 16'($urandom);
      cycle(er ? "err_hold" : "halt_hold", ev(9'h0, 6'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, er));
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < n; i++) cycle("rst_hold", 23'h0);
    reset = 1'b0;
    cycle("rst_state", 23'h0);
  endtask

  initial begin
    int code;
    logic [3:0] op;
    reset = 1'b1; Instruction = 16'h0; Status = 1'b0; mem_ready = 1'b0;
    do_reset(2);

    // Directed: each opcode class with zero wait, then with short waits.
    exec(16'h7000, 1'b0, 0, 0, -1, code);
    exec(16'h7000, 1'b1, 0, 0, -1, code);
    exec(16'h1030, 1'b0, 0, 0, -1, code);
    exec(16'h1030, 1'b0, 3, 3, -1, code);
    exec(16'h2000, 1'b0, 0, 0, -1, code);
    exec(16'h0001, 1'b0, 0, 0, -1, code);
    exec(16'h3005, 1'b0, 0, 0, -1, code);
    exec(16'h9005, 1'b0, 0, 0, -1, code);
    exec(16'h9005, 1'b1, 0, 0, -1, code);
    exec(16'h4003, 1'b0, 1, 4, -1, code);
    exec(16'h5000, 1'b0, 1, 4, -1, code);

    // Reset asserted while PUSH is waiting in its write step.
    exec(16'h1030, 1'b0, 1, 1, 6, code);
    do_reset(2);
    exec(16'h7000, 1'b0, 0, 0, -1, code);

    // HALT, then a fetch read that never completes.
    exec(16'h6000, 1'b0, 0, 2, -1, code);
    hold_check(5, 1'b0);
    do_reset(1);
    exec(16'h7000, 1'b0, 100, 100, -1, code);
    hold_check(5, 1'b1);
    do_reset(2);

    for (int n = 0; n < 1000; n++) begin
      op = 4'($urandom_range(15, 0));
      if (op == 4'h6 && $urandom_range(9, 0) != 0) op = 4'h7;
      exec({op, 12'($urandom)}, 1'($urandom), 0, 5, -1, code);
      if (code == 1) begin
        hold_check(2, 1'b0);
        do_reset(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
